// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write sequencer: latency-counted multiplier, restoring radix-2 divider,
// and MTHI/MTLO pass-through, with pipeline stall and one write pulse per op.
module hilo_muldiv_ctrl #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        op_ready,
    output logic        stall,
    output logic        whi,
    output logic        wlo,
    output logic [31:0] wHiData,
    output logic [31:0] wLoData,
    output logic        div_by_zero
);

    localparam int CNT_MAX = (MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITER - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [31:0]       mul_a_reg;
    logic [31:0]       mul_b_reg;
    logic              mul_signed_reg;
    logic [31:0]       quot_reg;
    logic [31:0]       rem_reg;
    logic [31:0]       dvsr_reg;
    logic              neg_q_reg;
    logic              neg_r_reg;

    logic              accept;
    logic              div_signed;
    logic [31:0]       a_mag;
    logic [31:0]       b_mag;
    logic signed [63:0] mul_a_ext;
    logic signed [63:0] mul_b_ext;
    logic [63:0]       mul_prod;
    logic [32:0]       div_shift;
    logic [32:0]       div_diff;
    logic              div_ge;
    logic [31:0]       rem_next;
    logic [31:0]       quot_next;
    logic [31:0]       quot_fin;
    logic [31:0]       rem_fin;

    assign op_ready = (state_reg == IDLE) && !rst;
    assign accept   = op_valid && op_ready && !flush;
    assign stall    = (state_reg == MUL) || (state_reg == DIV) || (accept && !op[2]);

    // Sign-extend only for MULT so one 64-bit product serves both flavours.
    assign mul_a_ext = {{32{mul_signed_reg & mul_a_reg[31]}}, mul_a_reg};
    assign mul_b_ext = {{32{mul_signed_reg & mul_b_reg[31]}}, mul_b_reg};
    assign mul_prod  = mul_a_ext * mul_b_ext;

    assign div_signed = (op == OP_DIV);
    assign a_mag      = (div_signed && src_a[31]) ? -src_a : src_a;
    assign b_mag      = (div_signed && src_b[31]) ? -src_b : src_b;

    // Remainder stays below the divisor, so bit 32 of the difference is the borrow.
    assign div_shift = {rem_reg, quot_reg[31]};
    assign div_diff  = div_shift - {1'b0, dvsr_reg};
    assign div_ge    = !div_diff[32];
    assign rem_next  = div_ge ? div_diff[31:0] : div_shift[31:0];
    assign quot_next = {quot_reg[30:0], div_ge};
    assign quot_fin  = neg_q_reg ? -quot_next : quot_next;
    assign rem_fin   = neg_r_reg ? -rem_next : rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            mul_a_reg      <= '0;
            mul_b_reg      <= '0;
            mul_signed_reg <= 1'b0;
            quot_reg       <= '0;
            rem_reg        <= '0;
            dvsr_reg       <= '0;
            neg_q_reg      <= 1'b0;
            neg_r_reg      <= 1'b0;
            whi            <= 1'b0;
            wlo            <= 1'b0;
            wHiData        <= '0;
            wLoData        <= '0;
            div_by_zero    <= 1'b0;
        end else begin
            whi         <= 1'b0;
            wlo         <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                mul_a_reg      <= src_a;
                                mul_b_reg      <= src_b;
                                mul_signed_reg <= (op == OP_MULT);
                                cnt_reg        <= '0;
                                state_reg      <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (src_b == 32'd0) begin
                                    whi         <= 1'b1;
                                    wlo         <= 1'b1;
                                    wHiData     <= src_a;
                                    wLoData     <= 32'hFFFF_FFFF;
                                    div_by_zero <= 1'b1;
                                    state_reg   <= DONE;
                                end else begin
                                    quot_reg  <= a_mag;
                                    rem_reg   <= '0;
                                    dvsr_reg  <= b_mag;
                                    neg_q_reg <= div_signed && (src_a[31] ^ src_b[31]);
                                    neg_r_reg <= div_signed && src_a[31];
                                    cnt_reg   <= '0;
                                    state_reg <= DIV;
                                end
                            end
                            OP_MTHI: begin
                                whi     <= 1'b1;
                                wHiData <= src_a;
                            end
                            OP_MTLO: begin
                                wlo     <= 1'b1;
                                wLoData <= src_a;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == MUL_LAST) begin
                        whi       <= 1'b1;
                        wlo       <= 1'b1;
                        wHiData   <= mul_prod[63:32];
                        wLoData   <= mul_prod[31:0];
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DIV: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        quot_reg <= quot_next;
                        rem_reg  <= rem_next;
                        if (cnt_reg == DIV_LAST) begin
                            whi       <= 1'b1;
                            wlo       <= 1'b1;
                            wHiData   <= rem_fin;
                            wLoData   <= quot_fin;
                            state_reg <= DONE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed-vector bench for hilo_muldiv_ctrl: stimulus pushes expected HI/LO writes
// (with their due cycle) into a queue; a negedge monitor pops and compares each write.
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        op_ready;
    logic        stall;
    logic        whi;
    logic        wlo;
    logic [31:0] wHiData;
    logic [31:0] wLoData;
    logic        div_by_zero;

    hilo_muldiv_ctrl #(.MUL_LAT(2), .DIV_ITER(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .op_ready(op_ready), .stall(stall), .whi(whi), .wlo(wlo),
        .wHiData(wHiData), .wLoData(wLoData), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        bit          hi_en;
        bit          lo_en;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dbz;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every write pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_write: got none expected write due cycle %0d", sb[0].cyc);
            void'(sb.pop_front());
        end
        if (whi || wlo || div_by_zero) begin
            $display("cycle %0d write whi=%b wlo=%b hi=%h lo=%h dbz=%b",
                     cyc, whi, wlo, wHiData, wLoData, div_by_zero);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got whi=%b wlo=%b expected no write", whi, wlo);
            end else begin
                mon_e = sb.pop_front();
                chk("write_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("whi", 64'(whi), 64'(mon_e.hi_en));
                chk("wlo", 64'(wlo), 64'(mon_e.lo_en));
                chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
                if (mon_e.hi_en) chk("wHiData", 64'(wHiData), 64'(mon_e.hi));
                if (mon_e.lo_en) chk("wLoData", 64'(wLoData), 64'(mon_e.lo));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int unsigned due, input bit he, input bit le,
                            input logic [31:0] hi, input logic [31:0] lo, input bit dz);
        exp_t e;
        e.cyc = due; e.hi_en = he; e.lo_en = le; e.hi = hi; e.lo = lo; e.dbz = dz;
        sb.push_back(e);
    endtask

    // Issue one op; lat = cycles from accept to write, exp_stall = stall-high cycle count.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit he, input bit le,
                          input logic [31:0] hi, input logic [31:0] lo, input bit dz,
                          input int lat, input int exp_stall, input bit hold);
        int sc;
        tick();
        chk({name, "_ready"}, 64'(op_ready), 64'd1);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        $display("cycle %0d issue %s a=%h b=%h", cyc, name, a, b);
        if (he || le) push_exp(cyc + lat, he, le, hi, lo, dz);
        sc = 0;
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            if (stall) sc++;
            if (i == lat && !o[2]) chk({name, "_ready_in_done"}, 64'(op_ready), 64'd0);
            tick();
            if (hold) begin
                op = 3'b101; src_a = 32'h1111_1111;
            end
            op_valid = hold && (i < lat);
        end
        chk({name, "_stall_cycles"}, 64'(sc), 64'(exp_stall));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op_valid = 1'b0; flush = 1'b0; op = 3'b111; src_a = '0; src_b = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_op_ready", 64'(op_ready), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_whi_wlo", 64'({whi, wlo, div_by_zero}), 64'd0);
        chk("rst_data", {wHiData, wLoData}, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(op_ready), 64'd1);

        run_op("mthi", 3'b100, 32'h1234_5678, 0, 1, 0, 32'h1234_5678, 0, 0, 1, 0, 0);
        run_op("mtlo", 3'b101, 32'h0BAD_F00D, 0, 0, 1, 0, 32'h0BAD_F00D, 0, 1, 0, 0);
        run_op("mult", 3'b000, 32'hFFFF_FFFD, 7, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 3, 3, 0);
        run_op("multu", 3'b001, 32'hFFFF_FFFD, 7, 1, 1, 32'h0000_0006, 32'hFFFF_FFEB, 0, 3, 3, 1);
        run_op("mult_min2", 3'b000, 32'h8000_0000, 2, 1, 1, 32'hFFFF_FFFF, 32'h0, 0, 3, 3, 0);
        run_op("multu_min2", 3'b001, 32'h8000_0000, 2, 1, 1, 32'h1, 32'h0, 0, 3, 3, 0);
        run_op("mult_minmin", 3'b000, 32'h8000_0000, 32'h8000_0000, 1, 1, 32'h4000_0000, 32'h0, 0, 3, 3, 0);
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 2, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 33, 33, 0);
        run_op("divu", 3'b011, 100, 7, 1, 1, 32'd2, 32'd14, 0, 33, 33, 1);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h0, 32'h8000_0000, 0, 33, 33, 0);
        run_op("div_negdvs", 3'b010, 7, 32'hFFFF_FFFE, 1, 1, 32'd1, 32'hFFFF_FFFD, 0, 33, 33, 0);
        run_op("divu_big", 3'b011, 32'hFFFF_FFFF, 16, 1, 1, 32'hF, 32'h0FFF_FFFF, 0, 33, 33, 0);
        run_op("divu_zero", 3'b011, 5, 0, 1, 1, 32'd5, 32'hFFFF_FFFF, 1, 1, 1, 0);
        run_op("div_zero", 3'b010, 32'h8000_0000, 0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 1, 0);
        run_op("nop", 3'b110, 32'h5555_5555, 3, 0, 0, 0, 0, 0, 1, 0, 0);

        // flush in the accept cycle blocks acceptance
        tick();
        op_valid = 1'b1; op = 3'b000; src_a = 3; src_b = 3; flush = 1'b1;
        @(negedge clk);
        chk("flush_block_stall", 64'(stall), 64'd0);
        tick();
        op = 3'b100; src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("flush_block_ready", 64'(op_ready), 64'd1);
        tick();
        op_valid = 1'b0; flush = 1'b0;

        // flush during DONE still writes
        tick();
        op_valid = 1'b1; op = 3'b001; src_a = 3; src_b = 5;
        $display("cycle %0d issue multu_flush_done", cyc);
        push_exp(cyc + 3, 1, 1, 32'd0, 32'd15, 0);
        tick(); op_valid = 1'b0;
        tick();
        tick(); flush = 1'b1;
        tick(); flush = 1'b0;
        @(negedge clk);
        chk("flush_done_ready", 64'(op_ready), 64'd1);

        // flush mid-divide
        tick();
        op_valid = 1'b1; op = 3'b010; src_a = 1000; src_b = 3;
        $display("cycle %0d issue div_flushed", cyc);
        tick(); op_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick(); flush = 1'b0;
        @(negedge clk);
        chk("flush_div_stall", 64'(stall), 64'd0);
        chk("flush_div_ready", 64'(op_ready), 64'd1);
        run_op("mtlo_after_flush", 3'b101, 32'hA5A5_A5A5, 0, 0, 1, 0, 32'hA5A5_A5A5, 0, 1, 0, 0);
        repeat (40) tick();

        // reset mid-divide
        tick();
        op_valid = 1'b1; op = 3'b011; src_a = 100; src_b = 7;
        $display("cycle %0d issue divu_reset", cyc);
        tick(); op_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 64'(op_ready), 64'd0);
        tick(); flush = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", 64'(stall), 64'd0);
        chk("rst_mid_pulses", 64'({whi, wlo, div_by_zero}), 64'd0);
        chk("rst_mid_data", {wHiData, wLoData}, 64'd0);
        chk("rst_mid_ready_held", 64'(op_ready), 64'd0);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 64'(op_ready), 64'd1);
        repeat (40) tick();

        run_op("mult_after_rst", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'h0, 32'h1, 0, 3, 3, 0);
        repeat (5) tick();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
